display_arbiter: RTL
====================

DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 Parameter SCAN_DIV, default 16: clk cycles each digit stays lit; legal range 2..65535.
REQ-002 Parameter HOLD_MIN, default 8: minimum full scan frames a grant is held before fixed-priority re-arbitration; legal range 1..255.
REQ-003 clk  in  1  single clock; all state changes on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 req  in  3  display requests; req[2] lockout blinker, req[1] backdoor scroller, req[0] lock FSM.
REQ-006 code0, code1, code2  in  20 each  four 5-bit SSD codes per requester; bits [19:15] are the leftmost digit.
REQ-007 grant  out  3  one-hot current owner, or 3'b000 when idle.
REQ-008 an  out  4  active-low digit enables; an[3] is the leftmost digit.
REQ-009 seg  out  7  active-low cathodes {g,f,e,d,c,b,a}.
REQ-010 frame  out  1  one-cycle pulse on the cycle the digit index wraps from 3 to 0.

Function
REQ-011 Divider counts 0..SCAN_DIV-1 and wraps; tick is asserted when the divider = SCAN_DIV-1.
REQ-012 On tick, digit index increments modulo 4; index 0 drives an=4'b0111 with code bits [19:15], index 3 drives an=4'b1110 with bits [4:0].
REQ-013 an and seg are registered and change exactly one cycle after tick; exactly one an bit is low while a grant exists.
REQ-014 Arbitration occurs only on a frame boundary (tick with index 3); grant never changes mid-frame.
REQ-015 At a boundary, a granted requester whose req is low loses the grant immediately, and a new grant is chosen by fixed priority req[2] > req[1] > req[0].
REQ-016 At a boundary, a granted requester whose req is high keeps the grant while hold_cnt < HOLD_MIN-1; otherwise fixed-priority re-arbitration runs, and the same owner may win again.
REQ-017 hold_cnt clears on any grant change and otherwise increments on each boundary, saturating at 255.
REQ-018 At every boundary, the new owner's code word is latched into a 20-bit shadow register; mid-frame changes on code* never reach the display.
REQ-019 With no grant, the shadow holds four blank codes and an=4'b1111.
REQ-020 A req that rises and falls between two boundaries is never granted.
REQ-021 Decode table: 0..9 give the standard digits; 10..15 give A,b,C,d,E,F; 16 L, 17 P, 18 n, 19 V, 20 '-', 21 '_', 22 blank; codes 23..31 decode to blank.
REQ-022 Segment examples: '0' -> 7'b1000000, '-' -> 7'b0111111, '_' -> 7'b1110111, blank -> 7'b1111111.

Reset
REQ-023 While rst is low at posedge clk: divider=0, index=0, grant=3'b000, hold_cnt=0, shadow=all blank, an=4'b1111, seg=7'b1111111, frame=0.
REQ-024 Reset asserted mid-frame blanks the display on the next clock; the first grant can occur at the first boundary after release.

Structure
REQ-025 SSD code constants 0..22 and the requester index constants belong in the shared lock package, together with the lock FSM codes.
REQ-026 Sub-module ssd_decoder holds the purely combinational 5-bit-code to 7-segment table; the arbiter instantiates it once on the selected shadow digit.

Verification
REQ-027 SCAN_DIV=4, HOLD_MIN=2, reset, req=3'b001, code0={C,L,5,d}: at the first boundary grant=001, then an cycles 0111,1011,1101,1110 every 4 clocks with seg = C,L,5,d.
REQ-028 Owner req[0] with hold_cnt=0; req[2] rises: grant stays 001 at the next boundary and becomes 100 at the following boundary.
REQ-029 Owner req[1]; req[1] drops mid-frame while req[0]=1: the current frame completes on the shadow, and grant=001 at the boundary regardless of hold_cnt.
REQ-030 Change code0 from {0,P,E,n} to {C,L,5,d} at index 1: the remaining digits of that frame still show P,E,n; the next frame shows C,L,5,d.
REQ-031 req=3'b000 at a boundary: grant=000, an=4'b1111, seg=7'b1111111; code 5'd25 under grant decodes to blank.
REQ-032 rst low for one cycle during index 2: the next cycle has an=4'b1111 and grant=000, and the divider restarts at 0.

Source files
------------

// File: rtl/display_arbiter_pkg.sv
// Shared lock package: SSD character codes, requester indices, grant encoding
// and lock FSM state codes used by the display path.
package display_arbiter_pkg;

    localparam logic [4:0] SSD_0     = 5'd0;
    localparam logic [4:0] SSD_1     = 5'd1;
    localparam logic [4:0] SSD_2     = 5'd2;
    localparam logic [4:0] SSD_3     = 5'd3;
    localparam logic [4:0] SSD_4     = 5'd4;
    localparam logic [4:0] SSD_5     = 5'd5;
    localparam logic [4:0] SSD_6     = 5'd6;
    localparam logic [4:0] SSD_7     = 5'd7;
    localparam logic [4:0] SSD_8     = 5'd8;
    localparam logic [4:0] SSD_9     = 5'd9;
    localparam logic [4:0] SSD_A     = 5'd10;
    localparam logic [4:0] SSD_B     = 5'd11;
    localparam logic [4:0] SSD_C     = 5'd12;
    localparam logic [4:0] SSD_D     = 5'd13;
    localparam logic [4:0] SSD_E     = 5'd14;
    localparam logic [4:0] SSD_F     = 5'd15;
    localparam logic [4:0] SSD_L     = 5'd16;
    localparam logic [4:0] SSD_P     = 5'd17;
    localparam logic [4:0] SSD_N     = 5'd18;
    localparam logic [4:0] SSD_V     = 5'd19;
    localparam logic [4:0] SSD_DASH  = 5'd20;
    localparam logic [4:0] SSD_UNDER = 5'd21;
    localparam logic [4:0] SSD_BLANK = 5'd22;

    localparam logic [19:0] BLANK_WORD = {SSD_BLANK, SSD_BLANK, SSD_BLANK, SSD_BLANK};

    localparam int REQ_LOCK    = 0;
    localparam int REQ_SCROLL  = 1;
    localparam int REQ_LOCKOUT = 2;

    typedef enum logic [2:0] {
        GNT_NONE    = 3'b000,
        GNT_LOCK    = 3'b001,
        GNT_SCROLL  = 3'b010,
        GNT_LOCKOUT = 3'b100
    } grant_t;

    typedef enum logic [2:0] {
        LOCK_IDLE    = 3'd0,
        LOCK_ENTRY   = 3'd1,
        LOCK_CHECK   = 3'd2,
        LOCK_OPEN    = 3'd3,
        LOCK_LOCKOUT = 3'd4
    } lock_state_t;

    function automatic grant_t pick_owner(input logic [2:0] r);
        if (r[REQ_LOCKOUT])     return GNT_LOCKOUT;
        else if (r[REQ_SCROLL]) return GNT_SCROLL;
        else if (r[REQ_LOCK])   return GNT_LOCK;
        else                    return GNT_NONE;
    endfunction

endpackage

// File: rtl/ssd_decoder.sv
// Combinational 5-bit SSD code to active-low {g,f,e,d,c,b,a} cathode pattern.
module ssd_decoder
    import display_arbiter_pkg::*;
(
    input  logic [4:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'b1111111;
        case (code)
            SSD_0:     seg = 7'b1000000;
            SSD_1:     seg = 7'b1111001;
            SSD_2:     seg = 7'b0100100;
            SSD_3:     seg = 7'b0110000;
            SSD_4:     seg = 7'b0011001;
            SSD_5:     seg = 7'b0010010;
            SSD_6:     seg = 7'b0000010;
            SSD_7:     seg = 7'b1111000;
            SSD_8:     seg = 7'b0000000;
            SSD_9:     seg = 7'b0010000;
            SSD_A:     seg = 7'b0001000;
            SSD_B:     seg = 7'b0000011;
            SSD_C:     seg = 7'b1000110;
            SSD_D:     seg = 7'b0100001;
            SSD_E:     seg = 7'b0000110;
            SSD_F:     seg = 7'b0001110;
            SSD_L:     seg = 7'b1000111;
            SSD_P:     seg = 7'b0001100;
            SSD_N:     seg = 7'b0101011;
            SSD_V:     seg = 7'b1000001;
            SSD_DASH:  seg = 7'b0111111;
            SSD_UNDER: seg = 7'b1110111;
            default:   seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/display_arbiter.sv
// Multiplexed 4-digit SSD driver shared by three requesters; ownership only
// moves on frame boundaries so a frame is always drawn from one latched word.
//
// state       | meaning
// GNT_NONE    | idle, display blanked
// GNT_LOCK    | req[0] lock FSM owns the display
// GNT_SCROLL  | req[1] backdoor scroller owns the display
// GNT_LOCKOUT | req[2] lockout blinker owns the display
module display_arbiter
    import display_arbiter_pkg::*;
#(
    parameter int SCAN_DIV = 16,
    parameter int HOLD_MIN = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [19:0] code0,
    input  logic [19:0] code1,
    input  logic [19:0] code2,
    output logic [2:0]  grant,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        frame
);

    localparam logic [15:0] DIV_LAST  = 16'(SCAN_DIV - 1);
    localparam logic [7:0]  HOLD_LAST = 8'(HOLD_MIN - 1);

    logic [15:0] div;
    logic [1:0]  idx, idx_d;
    logic [7:0]  hold_cnt, hold_d;
    logic [19:0] shadow, shadow_d;
    grant_t      gnt_q, gnt_d;
    logic        tick, boundary, keep;
    logic [4:0]  dig_code;
    logic [6:0]  seg_d;
    logic [3:0]  an_d;

    always_comb begin
        tick     = (div == DIV_LAST);
        boundary = tick && (idx == 2'd3);
        idx_d    = idx + 2'd1;
        gnt_d    = gnt_q;
        hold_d   = hold_cnt;
        shadow_d = shadow;
        keep     = 1'b0;
        if (boundary) begin
            keep = (gnt_q != GNT_NONE) && ((req & gnt_q) != 3'b000) && (hold_cnt < HOLD_LAST);
            if (!keep) gnt_d = pick_owner(req);
            if (gnt_d != gnt_q)        hold_d = 8'd0;
            else if (hold_cnt != 8'hFF) hold_d = hold_cnt + 8'd1;
            case (gnt_d)
                GNT_LOCKOUT: shadow_d = code2;
                GNT_SCROLL:  shadow_d = code1;
                GNT_LOCK:    shadow_d = code0;
                default:     shadow_d = BLANK_WORD;
            endcase
        end
        // digit about to be shown, taken from the word that will be latched
        case (idx_d)
            2'd0:    dig_code = shadow_d[19:15];
            2'd1:    dig_code = shadow_d[14:10];
            2'd2:    dig_code = shadow_d[9:5];
            default: dig_code = shadow_d[4:0];
        endcase
        an_d = (gnt_d == GNT_NONE) ? 4'b1111 : ~(4'b1000 >> idx_d);
    end

    ssd_decoder u_ssd_decoder (
        .code (dig_code),
        .seg  (seg_d)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            div      <= 16'd0;
            idx      <= 2'd0;
            gnt_q    <= GNT_NONE;
            hold_cnt <= 8'd0;
            shadow   <= BLANK_WORD;
            an       <= 4'b1111;
            seg      <= 7'b1111111;
            frame    <= 1'b0;
        end else begin
            div      <= tick ? 16'd0 : div + 16'd1;
            frame    <= boundary;
            gnt_q    <= gnt_d;
            hold_cnt <= hold_d;
            shadow   <= shadow_d;
            if (tick) begin
                idx <= idx_d;
                an  <= an_d;
                seg <= seg_d;
            end
        end
    end

    assign grant = gnt_q;

endmodule
